// File: rtl/vending_pkg.sv
// Shared types and coin encodings for the vending controller family.
// denom_value() maps a coin selector onto its value for a given denomination set.
package vending_pkg;

  typedef enum logic [1:0] {StIdle, StAccum, StVend, StChange} state_e;

  localparam logic [1:0] COIN_D0  = 2'd0;
  localparam logic [1:0] COIN_D1  = 2'd1;
  localparam logic [1:0] COIN_D2  = 2'd2;
  localparam logic [1:0] COIN_BAD = 2'd3;

  // A foreign coin is worth nothing.
  function automatic int unsigned denom_value(input logic [1:0] sel, input int unsigned d0,
                                              input int unsigned d1, input int unsigned d2);
    int unsigned v;
    case (sel)
      COIN_D0: v = d0;
      COIN_D1: v = d1;
      COIN_D2: v = d2;
      default: v = 0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vending_ctrl_if.sv
// Coin acceptor / dispenser / hopper signal bundle of the vending controller.
// master is the controller side; slave is the surrounding machine.
interface vending_ctrl_if #(
  parameter int unsigned CREDIT_W = 4,
  parameter int unsigned CNT_W    = 16
) ();

  logic                coin_valid;
  logic [1:0]          coin_sel;
  logic                coin_ready;
  logic                cancel;
  logic                coin_reject;
  logic                d;
  logic                chg_valid;
  logic [1:0]          chg_sel;
  logic                chg_ready;
  logic [CREDIT_W-1:0] credit;
  logic [CNT_W-1:0]    vend_count;

  modport master (
    input  coin_valid, coin_sel, cancel, chg_ready,
    output coin_ready, coin_reject, d, chg_valid, chg_sel, credit, vend_count
  );

  modport slave (
    output coin_valid, coin_sel, cancel, chg_ready,
    input  coin_ready, coin_reject, d, chg_valid, chg_sel, credit, vend_count
  );

endinterface

// File: rtl/vending_change_sel.sv
// Greedy change picker: largest denomination not exceeding the remaining credit.
// With DENOM_0 == 1 any positive credit always has a fitting coin.
module vending_change_sel
  import vending_pkg::*;
#(
  parameter int unsigned DENOM_0  = 1,
  parameter int unsigned DENOM_1  = 2,
  parameter int unsigned DENOM_2  = 5,
  parameter int unsigned CREDIT_W = 4
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [1:0]          chg_sel,
  output logic [CREDIT_W-1:0] chg_value
);

  localparam logic [CREDIT_W-1:0] Denom1W = CREDIT_W'(DENOM_1);
  localparam logic [CREDIT_W-1:0] Denom2W = CREDIT_W'(DENOM_2);

  always_comb begin
    chg_sel = COIN_D0;
    if (credit >= Denom2W) begin
      chg_sel = COIN_D2;
    end else if (credit >= Denom1W) begin
      chg_sel = COIN_D1;
    end
    chg_value = CREDIT_W'(denom_value(chg_sel, DENOM_0, DENOM_1, DENOM_2));
  end

endmodule

// File: rtl/vending_ctrl.sv
// Single-product vending controller: accumulates coins, pulses d once per vend,
// refunds on cancel and pays change one hopper handshake at a time.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int unsigned PRICE    = 5,
  parameter int unsigned DENOM_0  = 1,
  parameter int unsigned DENOM_1  = 2,
  parameter int unsigned DENOM_2  = 5,
  parameter int unsigned CREDIT_W = 4,
  parameter int unsigned CNT_W    = 16
) (
  input logic            clk,
  input logic            reset_n,
  vending_ctrl_if.master bus
);

  if (PRICE < 1) begin : g_chk_price
    $error("vending_ctrl: PRICE must be at least 1");
  end
  if (DENOM_0 != 1) begin : g_chk_d0
    $error("vending_ctrl: DENOM_0 must be 1 for exact change");
  end
  if (!(DENOM_0 < DENOM_1 && DENOM_1 < DENOM_2)) begin : g_chk_order
    $error("vending_ctrl: denominations must be strictly increasing");
  end
  if ((PRICE - 1 + DENOM_2) >= (64'd1 << CREDIT_W)) begin : g_chk_width
    $error("vending_ctrl: CREDIT_W too narrow for PRICE-1+DENOM_2");
  end

  localparam logic [CREDIT_W:0]   PriceWide = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] PriceW    = CREDIT_W'(PRICE);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                reject_q, reject_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] remain;
  logic [1:0]          pick_sel;
  logic [CREDIT_W-1:0] pick_value;

  vending_change_sel #(
    .DENOM_0 (DENOM_0),
    .DENOM_1 (DENOM_1),
    .DENOM_2 (DENOM_2),
    .CREDIT_W(CREDIT_W)
  ) u_change_sel (
    .credit   (credit_q),
    .chg_sel  (pick_sel),
    .chg_value(pick_value)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      credit_q <= '0;
      reject_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;
    count_d  = count_q;
    sum      = {1'b0, credit_q}
             + (CREDIT_W+1)'(denom_value(bus.coin_sel, DENOM_0, DENOM_1, DENOM_2));
    remain   = credit_q - PriceW;

    unique case (state_q)
      StIdle, StAccum: begin
        // Cancel wins over a coin offered in the same cycle: that coin is handed back.
        if (state_q == StAccum && bus.cancel) begin
          state_d  = StChange;
          reject_d = bus.coin_valid;
        end else if (bus.coin_valid) begin
          if (bus.coin_sel == COIN_BAD) begin
            reject_d = 1'b1;
          end else begin
            credit_d = sum[CREDIT_W-1:0];
            state_d  = (sum >= PriceWide) ? StVend : StAccum;
          end
        end
      end
      StVend: begin
        credit_d = remain;
        count_d  = count_q + CNT_W'(1);
        state_d  = (remain != '0) ? StChange : StIdle;
      end
      StChange: begin
        if (bus.chg_ready) begin
          credit_d = credit_q - pick_value;
          if (credit_q == pick_value) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.coin_ready  = (state_q == StIdle) || (state_q == StAccum);
  assign bus.d           = (state_q == StVend);
  assign bus.chg_valid   = (state_q == StChange);
  assign bus.chg_sel     = (state_q == StChange) ? pick_sel : COIN_D0;
  assign bus.credit      = credit_q;
  assign bus.coin_reject = reject_q;
  assign bus.vend_count  = count_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Directed bench for vending_ctrl: stimulus queues expected vend/reject/change events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_vending_ctrl;

  logic clk;
  logic reset_n;

  vending_ctrl_if #(.CREDIT_W(4), .CNT_W(16)) bus ();
  vending_ctrl_if #(.CREDIT_W(4), .CNT_W(2))  bus2 ();

  vending_ctrl #(
    .PRICE(5), .DENOM_0(1), .DENOM_1(2), .DENOM_2(5), .CREDIT_W(4), .CNT_W(16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  vending_ctrl #(
    .PRICE(5), .DENOM_0(1), .DENOM_1(2), .DENOM_2(5), .CREDIT_W(4), .CNT_W(2)
  ) dut_wrap (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus2)
  );

  typedef enum logic [1:0] {EvVend, EvReject, EvChg} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [1:0] sel;
    logic [3:0] credit;
  } ev_t;

  ev_t sb[$];
  int  n_pass  = 0;
  int  n_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input ev_kind_e kind, input logic [1:0] sel, input logic [3:0] credit);
    ev_t e;
    e.kind   = kind;
    e.sel    = sel;
    e.credit = credit;
    sb.push_back(e);
  endtask

  task automatic observe(input string name, input ev_kind_e kind, input logic [1:0] sel,
                         input logic [3:0] credit);
    ev_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s: unexpected event (sel %0d credit %0d), none queued", name, sel, credit);
    end else begin
      e = sb.pop_front();
      check(name, 32'({kind, sel, credit}), 32'({e.kind, e.sel, e.credit}));
    end
  endtask

  // Monitor: order within a cycle is vend, reject, change.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.d) observe("vend", EvVend, 2'd0, bus.credit);
        if (bus.coin_reject) observe("reject", EvReject, 2'd0, bus.credit);
        if (bus.chg_valid && bus.chg_ready) observe("change", EvChg, bus.chg_sel, bus.credit);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] sel);
    int w = 0;
    while (!bus.coin_ready && w < 50) begin
      step();
      w++;
    end
    check("coin_ready wait", 32'(bus.coin_ready), 32'd1);
    bus.coin_valid = 1'b1;
    bus.coin_sel   = sel;
    step();
    bus.coin_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!(bus.coin_ready && bus.credit == 4'd0) && w < 100) begin
      step();
      w++;
    end
    check("idle wait", 32'(bus.coin_ready && bus.credit == 4'd0), 32'd1);
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.coin_valid  = 1'b0;
    bus.coin_sel    = 2'd0;
    bus.cancel      = 1'b0;
    bus.chg_ready   = 1'b1;
    bus2.coin_valid = 1'b0;
    bus2.coin_sel   = 2'd0;
    bus2.cancel     = 1'b0;
    bus2.chg_ready  = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst credit", 32'(bus.credit), 32'd0);
    check("rst d", 32'(bus.d), 32'd0);
    check("rst chg_valid", 32'(bus.chg_valid), 32'd0);
    check("rst chg_sel", 32'(bus.chg_sel), 32'd0);
    check("rst coin_reject", 32'(bus.coin_reject), 32'd0);
    check("rst coin_ready", 32'(bus.coin_ready), 32'd1);
    check("rst vend_count", 32'(bus.vend_count), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    // 1: 2+2+1 exact price
    put_coin(2'd1);
    check("t1 credit a", 32'(bus.credit), 32'd2);
    put_coin(2'd1);
    check("t1 credit b", 32'(bus.credit), 32'd4);
    push(EvVend, 2'd0, 4'd5);
    put_coin(2'd0);
    check("t1 d at N+1", 32'(bus.d), 32'd1);
    check("t1 ready low in vend", 32'(bus.coin_ready), 32'd0);
    step();
    check("t1 d one cycle", 32'(bus.d), 32'd0);
    check("t1 ready at N+2", 32'(bus.coin_ready), 32'd1);
    check("t1 credit after", 32'(bus.credit), 32'd0);
    check("t1 vend_count", 32'(bus.vend_count), 32'd1);

    // 2: 2+2+5 = 9, change 2+2
    put_coin(2'd1);
    put_coin(2'd1);
    push(EvVend, 2'd0, 4'd9);
    push(EvChg, 2'd1, 4'd4);
    push(EvChg, 2'd1, 4'd2);
    put_coin(2'd2);
    wait_idle();
    check("t2 vend_count", 32'(bus.vend_count), 32'd2);

    // 3a: 1 then cancel refunds one DENOM_0
    put_coin(2'd0);
    push(EvChg, 2'd0, 4'd1);
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    check("t3 chg_valid", 32'(bus.chg_valid), 32'd1);
    check("t3 chg_sel", 32'(bus.chg_sel), 32'd0);
    wait_idle();
    // 3b: coin and cancel together, coin rejected
    put_coin(2'd1);
    push(EvReject, 2'd0, 4'd2);
    push(EvChg, 2'd1, 4'd2);
    bus.coin_valid = 1'b1;
    bus.coin_sel   = 2'd0;
    bus.cancel     = 1'b1;
    step();
    bus.coin_valid = 1'b0;
    bus.cancel     = 1'b0;
    check("t3 reject pulse", 32'(bus.coin_reject), 32'd1);
    check("t3 credit kept", 32'(bus.credit), 32'd2);
    wait_idle();
    check("t3 vend_count", 32'(bus.vend_count), 32'd2);

    // 4: foreign coin from IDLE
    push(EvReject, 2'd0, 4'd0);
    put_coin(2'd3);
    check("t4 reject", 32'(bus.coin_reject), 32'd1);
    check("t4 credit", 32'(bus.credit), 32'd0);
    check("t4 ready", 32'(bus.coin_ready), 32'd1);
    step();
    check("t4 reject one cycle", 32'(bus.coin_reject), 32'd0);

    // 5: hopper stall, change held and coins not consumed
    bus.chg_ready = 1'b0;
    put_coin(2'd1);
    push(EvVend, 2'd0, 4'd7);
    put_coin(2'd2);
    step();
    bus.coin_valid = 1'b1;
    bus.coin_sel   = 2'd0;
    for (int i = 0; i < 3; i++) begin
      check("t5 chg_valid held", 32'(bus.chg_valid), 32'd1);
      check("t5 chg_sel held", 32'(bus.chg_sel), 32'd1);
      check("t5 credit held", 32'(bus.credit), 32'd2);
      check("t5 ready low", 32'(bus.coin_ready), 32'd0);
      step();
    end
    bus.coin_valid = 1'b0;
    push(EvChg, 2'd1, 4'd2);
    bus.chg_ready = 1'b1;
    wait_idle();
    check("t5 vend_count", 32'(bus.vend_count), 32'd3);

    // 6: reset during CHANGE
    bus.chg_ready = 1'b0;
    put_coin(2'd1);
    push(EvVend, 2'd0, 4'd7);
    put_coin(2'd2);
    step();
    check("t6 in change", 32'(bus.chg_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6 rst chg_valid", 32'(bus.chg_valid), 32'd0);
    check("t6 rst credit", 32'(bus.credit), 32'd0);
    check("t6 rst vend_count", 32'(bus.vend_count), 32'd0);
    check("t6 rst chg_sel", 32'(bus.chg_sel), 32'd0);
    check("t6 rst ready", 32'(bus.coin_ready), 32'd1);
    step();
    reset_n       = 1'b1;
    bus.chg_ready = 1'b1;
    step();
    check("t6 idle after rst", 32'(bus.coin_ready && bus.credit == 4'd0), 32'd1);

    // 6b: 2-bit vend counter wraps
    for (int i = 1; i <= 5; i++) begin
      bus2.coin_valid = 1'b1;
      bus2.coin_sel   = 2'd2;
      step();
      bus2.coin_valid = 1'b0;
      check("wrap d", 32'(bus2.d), 32'd1);
      step();
      check("wrap vend_count", 32'(bus2.vend_count), 32'(i % 4));
    end

    step();
    step();
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
